// File: rtl/weight_init_ctrl_if.sv
// Host/RAM-side bus of weight_init_ctrl: external access, RAM port and status.
// slave = controller view, master = host + RAM view.
interface weight_init_ctrl_if #(
    parameter int AW = 7,
    parameter int DW = 10
);
    logic          Start;
    logic [AW-1:0] ExtAddr;
    logic [DW-1:0] ExtD;
    logic          ExtWE;
    logic [DW-1:0] RamQ;
    logic [AW-1:0] RamAddr;
    logic [DW-1:0] RamD;
    logic          RamWE;
    logic          Busy;
    logic          Done;
    logic          Err;

    modport slave (
        input  Start, ExtAddr, ExtD, ExtWE, RamQ,
        output RamAddr, RamD, RamWE, Busy, Done, Err
    );
    modport master (
        output Start, ExtAddr, ExtD, ExtWE, RamQ,
        input  RamAddr, RamD, RamWE, Busy, Done, Err
    );
endinterface

// File: rtl/weight_init_ctrl.sv
// Weight RAM initialiser: fills DEPTH words from a reseeded 10-bit LFSR, else passes host accesses through.
// Optional `WINIT_READBACK_CHECK_EN adds a readback pass that sets sticky Err on any mismatch.
module weight_init_ctrl #(
    parameter int         DEPTH = 65,
    parameter int         AW    = 7,
    parameter int         DW    = 10,
    parameter logic [9:0] SEED  = 10'h1A5,
    parameter int         SHIFT = 3
) (
    input  logic              Clock,
    input  logic              Rst,
    weight_init_ctrl_if.slave bus
);
    // An all-zero seed would lock the LFSR.
    localparam logic [9:0]    SEED_EFF = (SEED == 10'h000) ? 10'h001 : SEED;
    localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);

`ifdef WINIT_READBACK_CHECK_EN
    typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
`endif

    state_t            state, state_nx;
    logic [AW-1:0]     idx, idx_nx;
    logic [9:0]        lfsr, lfsr_nx, lfsr_step;
    logic signed [9:0] lfsr_sh;
    logic [DW-1:0]     weight;
    logic [AW-1:0]     ram_addr, ram_addr_nx;
    logic [DW-1:0]     ram_d, ram_d_nx;
    logic              ram_we, ram_we_nx;
    logic              busy, done, done_nx;

    assign lfsr_step = {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    assign lfsr_sh   = $signed(lfsr) >>> SHIFT;
    assign weight    = DW'(lfsr_sh);

`ifdef WINIT_READBACK_CHECK_EN
    // Expected word rides two stages: address register, then RAM read latency.
    logic [1:0]         vld_pipe, last_pipe;
    logic [1:0][DW-1:0] exp_pipe;
    logic               issue, err;
    assign issue = (state == CHECK) && !(|last_pipe);
`endif

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        lfsr_nx     = lfsr;
        ram_addr_nx = ram_addr;
        ram_d_nx    = ram_d;
        ram_we_nx   = 1'b0;
        done_nx     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.Start) begin
                    state_nx = FILL;
                    idx_nx   = '0;
                    lfsr_nx  = SEED_EFF;
                end else begin
                    ram_addr_nx = bus.ExtAddr;
                    ram_d_nx    = bus.ExtD;
                    ram_we_nx   = bus.ExtWE;
                end
            end
            FILL: begin
                ram_we_nx   = 1'b1;
                ram_addr_nx = idx;
                ram_d_nx    = weight;
                lfsr_nx     = lfsr_step;
                if (idx == LAST) begin
`ifdef WINIT_READBACK_CHECK_EN
                    state_nx = CHECK;
                    idx_nx   = '0;
                    lfsr_nx  = SEED_EFF;
`else
                    state_nx = DONE;
`endif
                end else begin
                    idx_nx = idx + AW'(1);
                end
            end
`ifdef WINIT_READBACK_CHECK_EN
            CHECK: begin
                if (issue) begin
                    ram_addr_nx = idx;
                    lfsr_nx     = lfsr_step;
                    if (idx != LAST) idx_nx = idx + AW'(1);
                end
                if (last_pipe[1]) state_nx = DONE;
            end
`endif
            DONE: begin
                done_nx  = 1'b1;
                idx_nx   = '0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            idx      <= '0;
            lfsr     <= SEED_EFF;
            ram_addr <= '0;
            ram_d    <= '0;
            ram_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            lfsr     <= lfsr_nx;
            ram_addr <= ram_addr_nx;
            ram_d    <= ram_d_nx;
            ram_we   <= ram_we_nx;
            busy     <= (state_nx != IDLE);
            done     <= done_nx;
        end
    end

`ifdef WINIT_READBACK_CHECK_EN
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            exp_pipe  <= '0;
            err       <= 1'b0;
        end else begin
            vld_pipe  <= {vld_pipe[0], issue};
            last_pipe <= {last_pipe[0], issue && (idx == LAST)};
            exp_pipe  <= {exp_pipe[0], weight};
            if (state == IDLE && bus.Start)
                err <= 1'b0;
            else if (vld_pipe[1] && (bus.RamQ != exp_pipe[1]))
                err <= 1'b1;
        end
    end
    assign bus.Err = err;
`else
    logic unused_ramq;
    assign unused_ramq = ^bus.RamQ;
    assign bus.Err     = 1'b0;
`endif

    assign bus.RamAddr = ram_addr;
    assign bus.RamD    = ram_d;
    assign bus.RamWE   = ram_we;
    assign bus.Busy    = busy;
    assign bus.Done    = done;
endmodule

// File: tb/tb_weight_init_ctrl.sv
// Directed bench for weight_init_ctrl: fill sequence, repeatability, passthrough,
// ignored restart, mid-fill reset and (with the readback macro) Err behaviour.
module tb_weight_init_ctrl;
    localparam int DEPTH = 65;
`ifdef WINIT_READBACK_CHECK_EN
    localparam int LAT = 2*DEPTH + 3;
`else
    localparam int LAT = DEPTH + 1;
`endif

    logic Clock = 1'b0;
    logic Rst   = 1'b0;
    always #5 Clock = ~Clock;

    weight_init_ctrl_if #(.AW(7), .DW(10)) bus();

    weight_init_ctrl #(
        .DEPTH(DEPTH), .AW(7), .DW(10), .SEED(10'h1A5), .SHIFT(3)
    ) dut (
        .Clock(Clock),
        .Rst  (Rst),
        .bus  (bus.slave)
    );

    // RAM model: shares Rst, 1-cycle read latency, optional corruption of addr 40.
    logic [9:0] mem [0:127];
    bit         corrupt = 1'b0;
    always @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < 128; i++) mem[i] <= '0;
            bus.RamQ <= '0;
        end else begin
            if (bus.RamWE)
                mem[bus.RamAddr] <= (corrupt && bus.RamAddr == 7'd40) ? (bus.RamD ^ 10'h001) : bus.RamD;
            bus.RamQ <= mem[bus.RamAddr];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    // Floor division by 8 of the signed LFSR value.
    function automatic logic [9:0] ref_weight(input logic [9:0] s);
        int v;
        v = s[9] ? int'(s) - 1024 : int'(s);
        if (v < 0) v = v - 7;
        return 10'(v / 8);
    endfunction

    logic [9:0] exp_d  [0:DEPTH-1];
    logic [9:0] run_d  [0:DEPTH-1];
    logic [9:0] save_d [0:DEPTH-1];
    int   nwr, first_we, last_we, done_cyc, n_done, bad_addr;
    logic err_start, err_done;

    task automatic run_init(input int restart_at, input int rst_at, output bit aborted);
        nwr = 0; first_we = -1; last_we = -1; done_cyc = -1; n_done = 0; bad_addr = 0;
        aborted = 1'b0; err_done = 1'b0;
        bus.Start = 1'b1;
        tick;
        bus.Start = 1'b0;
        err_start = bus.Err;
        check("busy_after_start", bus.Busy, 1);
        check("we_dropped_on_start", bus.RamWE, 0);
        for (int c = 1; c <= LAT + 10; c++) begin
            if (rst_at >= 0 && nwr == rst_at) begin
                Rst = 1'b0;
                #1;
                check("rst_we_low", bus.RamWE, 0);
                check("rst_busy_low", bus.Busy, 0);
                check("rst_addr_zero", bus.RamAddr, 0);
                #2 Rst = 1'b1;
                aborted = 1'b1;
                return;
            end
            bus.Start = (nwr == restart_at);
            tick;
            if (bus.RamWE) begin
                if (first_we < 0) first_we = c;
                last_we = c;
                if (nwr < DEPTH) begin
                    run_d[nwr] = bus.RamD;
                    if (bus.RamAddr != 7'(nwr)) bad_addr++;
                end
                nwr++;
            end
            if (bus.Done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc  = c;
                    err_done  = bus.Err;
                    bus.ExtWE = 1'b0;
                    check("busy_low_at_done", bus.Busy, 0);
                end
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        bus.Start = 1'b0;
        if (done_cyc < 0) check("done_timeout", 0, 1);
    endtask

    task automatic check_run(input string tag);
        int ndiff;
        ndiff = 0;
        for (int i = 0; i < DEPTH; i++) if (run_d[i] !== exp_d[i]) ndiff++;
        check({tag, "_writes"},   nwr, DEPTH);
        check({tag, "_first_we"}, first_we, 1);
        check({tag, "_last_we"},  last_we, DEPTH);
        check({tag, "_addr_seq"}, bad_addr, 0);
        check({tag, "_data"},     ndiff, 0);
        check({tag, "_done_lat"}, done_cyc, LAT);
        check({tag, "_done_cnt"}, n_done, 1);
    endtask

    initial begin
        logic [9:0] s;
        bit ab;
        int ndiff;
        bus.Start = 1'b0; bus.ExtAddr = '0; bus.ExtD = '0; bus.ExtWE = 1'b0;

        s = 10'h1A5;
        for (int i = 0; i < DEPTH; i++) begin
            exp_d[i] = ref_weight(s);
            s = {s[8:0], s[9] ^ s[6]};
        end

        repeat (3) @(posedge Clock);
        #1;
        check("rst_RamAddr", bus.RamAddr, 0);
        check("rst_RamD",    bus.RamD, 0);
        check("rst_RamWE",   bus.RamWE, 0);
        check("rst_Busy",    bus.Busy, 0);
        check("rst_Done",    bus.Done, 0);
        check("rst_Err",     bus.Err, 0);
        #2 Rst = 1'b1;
        tick; tick;

        // basic fill
        run_init(-1, -1, ab);
        check_run("t1");
        check("t1_d0", run_d[0], 10'd52);
        check("t1_d1", run_d[1], 10'h3E9);
        check("t1_err", bus.Err, 0);
        for (int i = 0; i < DEPTH; i++) save_d[i] = run_d[i];

        // idle passthrough
        bus.ExtAddr = 7'd5; bus.ExtD = 10'h3F9; bus.ExtWE = 1'b1;
        tick;
        check("pt_addr", bus.RamAddr, 5);
        check("pt_d",    bus.RamD, 10'h3F9);
        check("pt_we",   bus.RamWE, 1);
        bus.ExtWE = 1'b0;
        tick;
        check("pt_we_off", bus.RamWE, 0);
        check("pt_mem5",   mem[5], 10'h3F9);

        // second run with external write held high: identical sequence, no stray write
        tick; tick;
        bus.ExtAddr = 7'd100; bus.ExtD = 10'h155; bus.ExtWE = 1'b1;
        run_init(-1, -1, ab);
        check_run("t2");
        ndiff = 0;
        for (int i = 0; i < DEPTH; i++) if (run_d[i] !== save_d[i]) ndiff++;
        check("t2_repeat", ndiff, 0);
        check("t2_no_ext_write", mem[100], 0);

        // Start re-pulsed mid-fill
        tick; tick; tick;
        run_init(20, -1, ab);
        check_run("t4");

        // reset mid-fill, then restart
        tick; tick;
        run_init(-1, 30, ab);
        check("t5_aborted", ab, 1);
        check("t5_writes", nwr, 30);
        tick; tick;
        check("t5_idle_we", bus.RamWE, 0);
        check("t5_idle_busy", bus.Busy, 0);
        run_init(-1, -1, ab);
        check_run("t5r");
        check("t5_d0", run_d[0], 10'd52);

`ifdef WINIT_READBACK_CHECK_EN
        // corrupted readback sets sticky Err; next Start clears it
        tick; tick;
        corrupt = 1'b1;
        run_init(-1, -1, ab);
        check_run("t6");
        check("t6_err_at_done", err_done, 1);
        tick; tick; tick;
        check("t6_err_sticky", bus.Err, 1);
        corrupt = 1'b0;
        run_init(-1, -1, ab);
        check("t6_err_cleared", err_start, 0);
        check("t6_clean_err", err_done, 0);
        check_run("t6c");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/weight_init_ctrl.md
Name: weight_init_ctrl

Overview:
Sequencer that sits directly upstream of the weight RAM and owns its write port.
- On Start, writes a repeatable pseudo-random signed weight into every RAM address, then signals Done.
- While idle, passes external (training/host) accesses through to the RAM.
- Weight values come from an internal 10-bit LFSR, reseeded on every Start, so initial weights are reproducible run to run.

Parameters:
DEPTH, 65, number of weight words to initialise (addresses 0..DEPTH-1)
AW, 7, RAM address width
DW, 10, weight width (signed, two's complement)
SEED, 10'h1A5, LFSR seed loaded on every Start; a value of 0 is replaced by 10'h001
SHIFT, 3, arithmetic right shift applied to the LFSR word to set initial weight magnitude

Ports:
Clock  in  1  single clock, rising edge
Rst  in  1  asynchronous, active-low reset
Start  in  1  one-cycle request to begin initialisation; sampled only in IDLE
ExtAddr  in  AW  external access address (IDLE only)
ExtD  in  DW  external write data (IDLE only)
ExtWE  in  1  external write enable, 1=write, 0=read (IDLE only)
RamQ  in  DW  RAM read data; RAM read latency is 1 cycle
RamAddr  out  AW  RAM address
RamD  out  DW  RAM write data
RamWE  out  1  RAM write enable
Busy  out  1  high in any state other than IDLE
Done  out  1  one-cycle pulse when initialisation completes
Err  out  1  sticky readback mismatch flag (WINIT_READBACK_CHECK_EN only; tied 0 otherwise)

Behaviour:
- Clock and reset are fixed:
  - One clock, Clock.
  - Reset Rst is asynchronous and active-low.
- All outputs are registered.
- Reset values: RamAddr=0, RamD=0, RamWE=0, Busy=0, Done=0, Err=0.
- Reset internal state: state=IDLE, idx=0, lfsr=SEED.

LFSR:
- 10-bit Fibonacci LFSR, polynomial x^10+x^7+1.
- Next value = {lfsr[8:0], lfsr[9]^lfsr[6]}.
- Weight = $signed(lfsr) >>> SHIFT, width DW.

FSM states:
- IDLE:
  - RamAddr/RamD/RamWE <= ExtAddr/ExtD/ExtWE, giving 1-cycle passthrough latency.
  - Start=1: lfsr<=SEED, idx<=0, go to FILL. The Ext inputs on that cycle are dropped and RamWE<=0.
- FILL:
  - Each cycle: RamWE<=1, RamAddr<=idx, RamD<=weight(lfsr); then lfsr advances and idx++.
  - After the write of idx=DEPTH-1, go to DONE (or CHECK when the feature is enabled).
  - Exactly DEPTH write cycles; no gaps.
- DONE:
  - RamWE<=0, Done<=1 for exactly one cycle, then IDLE.
  - Busy drops in the same cycle the FSM enters IDLE.

Boundary conditions:
- Start while Busy=1 is ignored; no restart.
- Ext* inputs are ignored while Busy=1; the RAM sees no external writes during init.
- idx never exceeds DEPTH-1; no address wrap occurs.
- Rst asserted mid-FILL:
  - Immediate return to reset values; RamWE low asynchronously.
  - The partial fill is abandoned. The RAM shares Rst and therefore clears.
- Start and Rst deasserting on the same edge: the reset wins; Start is not seen.
- Latency from Start sampled to Done pulse: DEPTH+1 cycles without the feature.

Optional Feature:
Macro WINIT_READBACK_CHECK_EN.
- When defined, FILL goes to CHECK instead of DONE.
- On entering CHECK: lfsr<=SEED, idx<=0.
- Each cycle: RamWE<=0, RamAddr<=idx, lfsr advances.
- The expected weight is delayed 2 cycles (address register plus RAM latency) and compared with RamQ.
- Any mismatch sets Err. Err stays set until the next accepted Start or reset.
- After the last compare, go to DONE. Start-to-Done latency becomes 2*DEPTH+3 cycles.
- When not defined: the CHECK state is absent, Err is constant 0, and RamQ is unused.

Test Plan:
1. Reset, then Start pulse (SEED=10'h1A5, SHIFT=3) -> RamWE high for 65 consecutive cycles, addresses 0..64 in order; addr0 D=52, addr1 D=-23 (10'h3E9); Done pulse 66 cycles after Start.
2. Two Start runs separated by idle cycles -> identical 65-word write sequences on both runs.
3. IDLE passthrough: ExtAddr=5, ExtD=-7, ExtWE=1 -> next cycle RamAddr=5, RamD=10'h3F9, RamWE=1; during Busy, ExtWE=1 produces no external write.
4. Start re-pulsed at FILL idx=20 -> ignored; sequence continues to 64 with a single Done.
5. Rst low at idx=30 -> RamWE=0 and Busy=0 immediately; after release, Start restarts the fill from addr0 with D=52.
6. (WINIT_READBACK_CHECK_EN) RAM model corrupts addr 40 -> Err=1 before Done and stays set; the next Start clears it, and a clean rerun leaves Err=0.
